// File: rtl/fifo_if_pkg.sv
// ============================================================================
// Module  : fifo_if_pkg
// Brief   : Shared definitions for the dual-clock FIFO write/read interfaces.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_if_pkg;

    localparam int DW_DEFAULT = 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_LOAD      = 3'd2;
    localparam logic [2:0] S_HANDSHAKE = 3'd3;
    localparam logic [2:0] S_RELEASE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = S_IDLE,
        FETCH     = S_FETCH,
        LOAD      = S_LOAD,
        HANDSHAKE = S_HANDSHAKE,
        RELEASE   = S_RELEASE
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_if2_reader_hs_timeout.sv
// ============================================================================
// Module  : hs_timeout
// Brief   : Saturating handshake wait counter with sticky timeout error flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_2,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic err
);

    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] c_MAX = WW'(TIMEOUT);
    localparam logic [WW-1:0] c_PRE = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

    logic [WW-1:0] r_wait_cnt;
    logic          r_err;

    // err rises on the same edge that wait_cnt lands on TIMEOUT
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (clear) begin
                r_wait_cnt <= '0;
            end else if (en && (r_wait_cnt != c_MAX)) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end
            if ((TIMEOUT != 0) && en && ((r_wait_cnt == c_PRE) || (r_wait_cnt == c_MAX))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;

endmodule

`default_nettype wire

// File: rtl/fifo_if2_reader.sv
// ============================================================================
// Module  : fifo_if2_reader
// Brief   : FIFO read-side interface: pops words and delivers them over req/ack.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_if2_reader
    import fifo_if_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int CW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          rempty,
    input  logic [DW-1:0] rdata,
    output logic          rinc,
    output logic          IF2_req,
    output logic [DW-1:0] IF2_data,
    input  logic          ack,
    output logic [CW-1:0] xfer_cnt,
    output logic          err
);

    state_e        r_state;
    logic          r_req;
    logic [DW-1:0] r_data;
    logic [CW-1:0] r_xfer_cnt;
    logic          w_hs_clear;
    logic          w_hs_en;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_data     <= '0;
            r_xfer_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= FETCH;
                FETCH: begin
                    if (!rempty) r_state <= LOAD;
                end
                // FIFO output register holds the popped word during LOAD
                LOAD: begin
                    r_data  <= rdata;
                    r_req   <= 1'b1;
                    r_state <= HANDSHAKE;
                end
                HANDSHAKE: begin
                    if (ack) begin
                        r_req      <= 1'b0;
                        r_xfer_cnt <= r_xfer_cnt + CW'(1);
                        r_state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack) r_state <= FETCH;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rinc       = (r_state == FETCH) && !rempty;
    assign w_hs_clear = (r_state == HANDSHAKE) && ack;
    assign w_hs_en    = (r_state == HANDSHAKE) && !ack;

    hs_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_hs_timeout (
        .clk_2 (clk_2),
        .reset (reset),
        .clear (w_hs_clear),
        .en    (w_hs_en),
        .err   (err)
    );

    assign IF2_req  = r_req;
    assign IF2_data = r_data;
    assign xfer_cnt = r_xfer_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_if2_reader.sv
// ============================================================================
// Module  : tb_fifo_if2_reader
// Brief   : Directed self-checking bench for fifo_if2_reader with a FIFO model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_if2_reader;

    localparam int DW      = 4;
    localparam int CW      = 2;
    localparam int TIMEOUT = 8;

    logic          clk_2 = 1'b0;
    logic          reset;
    logic          rempty = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          rinc;
    logic          IF2_req;
    logic [DW-1:0] IF2_data;
    logic          ack;
    logic [CW-1:0] xfer_cnt;
    logic          err;

    logic [DW-1:0] fifo_q[$];
    int            pops = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    fifo_if2_reader #(
        .DW      (DW),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .IF2_req  (IF2_req),
        .IF2_data (IF2_data),
        .ack      (ack),
        .xfer_cnt (xfer_cnt),
        .err      (err)
    );

    always #5 clk_2 = ~clk_2;

    // FIFO model: registered read data, empty flag follows queue occupancy
    always @(posedge clk_2) begin
        if (rinc) begin
            pops <= pops + 1;
            if (fifo_q.size() != 0) rdata <= fifo_q.pop_front();
        end
        rempty <= (fifo_q.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_2);
    endtask

    task automatic wait_req(input int max_cyc);
        int n;
        n = 0;
        while (IF2_req !== 1'b1 && n < max_cyc) begin
            @(negedge clk_2);
            n++;
        end
        chk("wait_req", {31'd0, IF2_req}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n_rinc;
        int            n_req;
        int            pops_base;
        logic [DW-1:0] words [5];
        logic [CW-1:0] cnts  [5];
        words = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
        cnts  = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

        reset = 1'b1;
        ack   = 1'b0;
        step(2);
        chk("rst_req",  {31'd0, IF2_req}, 32'd0);
        chk("rst_data", {28'd0, IF2_data}, 32'd0);
        chk("rst_cnt",  {30'd0, xfer_cnt}, 32'd0);
        chk("rst_err",  {31'd0, err}, 32'd0);
        chk("rst_rinc", {31'd0, rinc}, 32'd0);
        reset = 1'b0;

        // Empty FIFO for 20 cycles, stray ack must be ignored
        ack    = 1'b1;
        n_rinc = 0;
        n_req  = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (rinc)    n_rinc++;
            if (IF2_req) n_req++;
        end
        ack = 1'b0;
        chk("empty_rinc", n_rinc, 0);
        chk("empty_req",  n_req, 0);
        chk("empty_data", {28'd0, IF2_data}, 32'd0);
        chk("empty_cnt",  {30'd0, xfer_cnt}, 32'd0);
        chk("empty_err",  {31'd0, err}, 32'd0);

        // Two words with exact latency
        fifo_q.push_back(4'hA);
        fifo_q.push_back(4'h5);
        step(1);
        chk("w1_rinc", {31'd0, rinc}, 32'd1);
        step(1);
        chk("w1_rinc_pulse", {31'd0, rinc}, 32'd0);
        chk("w1_req_early",  {31'd0, IF2_req}, 32'd0);
        step(1);
        chk("w1_req",  {31'd0, IF2_req}, 32'd1);
        chk("w1_data", {28'd0, IF2_data}, 32'h0A);
        step(1);
        chk("w1_hold", {31'd0, IF2_req}, 32'd1);
        ack = 1'b1;
        step(1);
        chk("w1_cnt", {30'd0, xfer_cnt}, 32'd1);
        chk("w1_drop", {31'd0, IF2_req}, 32'd0);
        // ack held high: no new pop or request
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("ackhi_req",  {31'd0, IF2_req}, 32'd0);
            chk("ackhi_rinc", {31'd0, rinc}, 32'd0);
            chk("ackhi_data", {28'd0, IF2_data}, 32'h0A);
        end
        ack = 1'b0;
        step(1);
        chk("w2_rinc", {31'd0, rinc}, 32'd1);
        step(2);
        chk("w2_req",  {31'd0, IF2_req}, 32'd1);
        chk("w2_data", {28'd0, IF2_data}, 32'h05);
        ack = 1'b1;
        step(1);
        chk("w2_cnt", {30'd0, xfer_cnt}, 32'd2);
        ack = 1'b0;
        step(1);
        chk("w2_norinc", {31'd0, rinc}, 32'd0);
        chk("w2_pops", pops, 2);

        // Timeout: no ack for 8 handshake cycles
        fifo_q.push_back(4'h3);
        wait_req(8);
        chk("to_err0", {31'd0, err}, 32'd0);
        step(7);
        chk("to_err7", {31'd0, err}, 32'd0);
        step(1);
        chk("to_err8", {31'd0, err}, 32'd1);
        chk("to_req",  {31'd0, IF2_req}, 32'd1);
        chk("to_data", {28'd0, IF2_data}, 32'h03);
        step(3);
        chk("to_hold", {31'd0, IF2_req}, 32'd1);
        ack = 1'b1;
        step(1);
        chk("to_cnt",     {30'd0, xfer_cnt}, 32'd3);
        chk("to_sticky",  {31'd0, err}, 32'd1);
        ack = 1'b0;
        step(1);

        // Reset mid-handshake
        fifo_q.push_back(4'h7);
        fifo_q.push_back(4'h9);
        wait_req(8);
        chk("mr_data", {28'd0, IF2_data}, 32'h07);
        reset = 1'b1;
        #1;
        chk("mr_req",  {31'd0, IF2_req}, 32'd0);
        chk("mr_data0", {28'd0, IF2_data}, 32'd0);
        chk("mr_err",  {31'd0, err}, 32'd0);
        chk("mr_cnt",  {30'd0, xfer_cnt}, 32'd0);
        step(2);
        reset = 1'b0;
        chk("mr_idle", {31'd0, rinc}, 32'd0);
        step(1);
        chk("mr_fetch", {31'd0, rinc}, 32'd1);
        step(2);
        chk("mr_req2",  {31'd0, IF2_req}, 32'd1);
        chk("mr_data9", {28'd0, IF2_data}, 32'h09);
        ack = 1'b1;
        step(1);
        chk("mr_cnt1", {30'd0, xfer_cnt}, 32'd1);
        ack = 1'b0;
        step(1);

        // Five back-to-back words, counter wraps at 4
        pops_base = pops;
        for (int i = 0; i < 5; i++) fifo_q.push_back(words[i]);
        for (int i = 0; i < 5; i++) begin
            wait_req(6);
            chk("b2b_data", {28'd0, IF2_data}, {28'd0, words[i]});
            ack = 1'b1;
            step(1);
            chk("b2b_cnt", {30'd0, xfer_cnt}, {30'd0, cnts[i]});
            chk("b2b_req", {31'd0, IF2_req}, 32'd0);
            ack = 1'b0;
            step(1);
        end
        step(6);
        chk("b2b_idle", {31'd0, IF2_req}, 32'd0);
        chk("b2b_pops", pops - pops_base, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
